// File: rtl/cpu_phase_sequencer.sv
// Per-instruction phase sequencer: FETCH/DECODE/EXECUTE/WRBK/JMP strobes, PC and retired count.
// Optional single-step start from IDLE is enabled by defining SEQ_SINGLE_STEP_EN.
module cpu_phase_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        halt_req,
  input  logic        step,
  input  logic        mem_ready,
  input  logic        set_pc,
  input  logic [15:0] jump_addr,
  output logic [15:0] pc,
  output logic        fetch_stb,
  output logic        decode_stb,
  output logic        exec_stb,
  output logic        wrbk_stb,
  output logic        jmp_stb,
  output logic        halted,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WRBK   = 3'd4,
    S_JMP    = 3'd5
  } state_t;

  state_t      state_r, state_nx_s;
  logic        step_go_s;
  logic        step_active_r;
  logic [4:0]  stb_nx_s, stb_r;
  logic        halted_nx_s, halted_r;
  logic [15:0] pc_r, instr_count_r;

`ifdef SEQ_SINGLE_STEP_EN
  assign step_go_s = step & ~run;
`else
  logic unused_step_s;
  assign unused_step_s = step;
  assign step_go_s     = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode; illegal encodings recover to IDLE
  always_comb begin
    state_nx_s = S_IDLE;
    case (state_r)
      S_IDLE: begin
        if (run || step_go_s) state_nx_s = S_FETCH;
        else                  state_nx_s = S_IDLE;
      end
      S_FETCH:  state_nx_s = S_DECODE;
      S_DECODE: state_nx_s = S_EXEC;
      S_EXEC:   state_nx_s = S_WRBK;
      S_WRBK: begin
        if (mem_ready) state_nx_s = S_JMP;
        else           state_nx_s = S_WRBK;
      end
      S_JMP: begin
        if (halt_req || !run || step_active_r) state_nx_s = S_IDLE;
        else                                   state_nx_s = S_FETCH;
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Strobe/halted decode from the upcoming state, so outputs can be registered
  always_comb begin
    stb_nx_s    = 5'b00000;
    halted_nx_s = 1'b0;
    case (state_nx_s)
      S_IDLE:   halted_nx_s = 1'b1;
      S_FETCH:  stb_nx_s[0] = 1'b1;
      S_DECODE: stb_nx_s[1] = 1'b1;
      S_EXEC:   stb_nx_s[2] = 1'b1;
      S_WRBK: begin
        if (state_r != S_WRBK) stb_nx_s[3] = 1'b1;
        else                   stb_nx_s    = 5'b00000;
      end
      S_JMP:    stb_nx_s[4] = 1'b1;
      default:  halted_nx_s = 1'b1;
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_r    <= 5'b00000;
      halted_r <= 1'b1;
    end else begin
      stb_r    <= stb_nx_s;
      halted_r <= halted_nx_s;
    end
  end

  // PC, retired count and single-step tracking, all committed at the JMP edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r          <= RESET_PC;
      instr_count_r <= 16'h0000;
      step_active_r <= 1'b0;
    end else if (state_r == S_JMP) begin
      pc_r          <= set_pc ? jump_addr : pc_r + 16'd1;
      instr_count_r <= instr_count_r + 16'd1;
      step_active_r <= 1'b0;
    end else if ((state_r == S_IDLE) && (state_nx_s == S_FETCH)) begin
      step_active_r <= step_go_s;
    end else begin
      step_active_r <= step_active_r;
    end
  end

  assign pc          = pc_r;
  assign instr_count = instr_count_r;
  assign fetch_stb   = stb_r[0];
  assign decode_stb  = stb_r[1];
  assign exec_stb    = stb_r[2];
  assign wrbk_stb    = stb_r[3];
  assign jmp_stb     = stb_r[4];
  assign halted      = halted_r;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Bench for cpu_phase_sequencer: vector table, directed corner sequences and a
// randomized run against an instruction-progress reference model.
module tb_cpu_phase_sequencer;

`ifdef SEQ_SINGLE_STEP_EN
  localparam int STEP_EN = 1;
`else
  localparam int STEP_EN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, run, halt_req, step, mem_ready, set_pc;
  logic [15:0] jump_addr;
  logic [15:0] pc, instr_count;
  logic        fetch_stb, decode_stb, exec_stb, wrbk_stb, jmp_stb, halted;

  int checks = 0;
  int failures = 0;

  cpu_phase_sequencer #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .halt_req(halt_req), .step(step),
    .mem_ready(mem_ready), .set_pc(set_pc), .jump_addr(jump_addr), .pc(pc),
    .fetch_stb(fetch_stb), .decode_stb(decode_stb), .exec_stb(exec_stb),
    .wrbk_stb(wrbk_stb), .jmp_stb(jmp_stb), .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Reference model: where we are inside the current instruction
  bit          m_busy, m_jmp, m_stepping;
  int          m_k;
  logic [15:0] m_pc, m_cnt;

  function automatic logic [4:0] dut_stb();
    return {jmp_stb, wrbk_stb, exec_stb, decode_stb, fetch_stb};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_jmp = 1'b0; m_stepping = 1'b0; m_k = 0;
    m_pc = 16'h0000; m_cnt = 16'h0000;
  endtask

  task automatic model_step();
    if (!m_busy) begin
      if (run) begin
        m_busy = 1'b1; m_k = 0; m_stepping = 1'b0;
      end else if (STEP_EN != 0 && step) begin
        m_busy = 1'b1; m_k = 0; m_stepping = 1'b1;
      end
    end else if (m_jmp) begin
      m_pc  = set_pc ? jump_addr : m_pc + 16'd1;
      m_cnt = m_cnt + 16'd1;
      m_jmp = 1'b0;
      if (halt_req || !run || m_stepping) m_busy = 1'b0;
      else m_k = 0;
    end else if (m_k < 3) begin
      m_k++;
    end else if (mem_ready) begin
      m_jmp = 1'b1;
    end else begin
      m_k++;
    end
  endtask

  function automatic logic [4:0] model_stb();
    if (!m_busy) return 5'b00000;
    if (m_jmp) return 5'b10000;
    case (m_k)
      0: return 5'b00001;
      1: return 5'b00010;
      2: return 5'b00100;
      3: return 5'b01000;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic check_model();
    check("model_stb", {27'd0, dut_stb()}, {27'd0, model_stb()});
    check("model_halted", {31'd0, halted}, {31'd0, !m_busy});
    check("model_pc", {16'd0, pc}, {16'd0, m_pc});
    check("model_cnt", {16'd0, instr_count}, {16'd0, m_cnt});
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    @(negedge clk);
    check_model();
  endtask

  // One instruction with halt pending; waits (bounded) until back in IDLE
  task automatic run_one(input logic sp, input logic [15:0] addr);
    int n;
    run = 1'b1; halt_req = 1'b1; mem_ready = 1'b1; set_pc = sp; jump_addr = addr;
    tick();
    n = 0;
    while (!halted && n < 30) begin
      tick();
      n++;
    end
    check("run_one_done", {31'd0, halted}, 32'd1);
    run = 1'b0; halt_req = 1'b0; set_pc = 1'b0;
  endtask

  typedef struct {
    logic        run, halt_req, mem_ready, set_pc;
    logic [15:0] jump_addr;
    logic [4:0]  exp_stb;
    logic        exp_halted;
    logic [15:0] exp_pc, exp_cnt;
  } vec_t;

  function automatic vec_t mk(logic r, logic h, logic m, logic s, logic [15:0] a,
                              logic [4:0] es, logic eh, logic [15:0] ep, logic [15:0] ec);
    vec_t v;
    v.run = r; v.halt_req = h; v.mem_ready = m; v.set_pc = s; v.jump_addr = a;
    v.exp_stb = es; v.exp_halted = eh; v.exp_pc = ep; v.exp_cnt = ec;
    return v;
  endfunction

  vec_t vecs[10];

  initial begin
    int n;
    logic [15:0] base;

    // From reset: halt raised in DECODE, 3-cycle WRBK stall, jump to 0x0040
    vecs[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 5'b00001, 1'b0, 16'h0000, 16'd0);
    vecs[1] = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 5'b00010, 1'b0, 16'h0000, 16'd0);
    vecs[2] = mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 5'b00100, 1'b0, 16'h0000, 16'd0);
    vecs[3] = mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 5'b01000, 1'b0, 16'h0000, 16'd0);
    vecs[4] = mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 5'b00000, 1'b0, 16'h0000, 16'd0);
    vecs[5] = mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 5'b00000, 1'b0, 16'h0000, 16'd0);
    vecs[6] = mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 5'b00000, 1'b0, 16'h0000, 16'd0);
    vecs[7] = mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 5'b10000, 1'b0, 16'h0000, 16'd0);
    vecs[8] = mk(1'b1, 1'b1, 1'b1, 1'b1, 16'h0040, 5'b00000, 1'b1, 16'h0040, 16'd1);
    vecs[9] = mk(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 5'b00000, 1'b1, 16'h0040, 16'd1);

    rst_n = 1'b0; run = 1'b0; halt_req = 1'b0; step = 1'b0;
    mem_ready = 1'b0; set_pc = 1'b0; jump_addr = 16'h0000;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("reset_stb", {27'd0, dut_stb()}, 32'd0);
    check("reset_halted", {31'd0, halted}, 32'd1);
    check("reset_pc", {16'd0, pc}, 32'h0000);
    check("reset_cnt", {16'd0, instr_count}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      run = vecs[i].run; halt_req = vecs[i].halt_req; mem_ready = vecs[i].mem_ready;
      set_pc = vecs[i].set_pc; jump_addr = vecs[i].jump_addr;
      tick();
      check($sformatf("vec%0d_stb", i), {27'd0, dut_stb()}, {27'd0, vecs[i].exp_stb});
      check($sformatf("vec%0d_halted", i), {31'd0, halted}, {31'd0, vecs[i].exp_halted});
      check($sformatf("vec%0d_pc", i), {16'd0, pc}, {16'd0, vecs[i].exp_pc});
      check($sformatf("vec%0d_cnt", i), {16'd0, instr_count}, {16'd0, vecs[i].exp_cnt});
    end
    halt_req = 1'b0;
    repeat (3) tick();
    check("halt_no_fetch", {27'd0, dut_stb()}, 32'd0);

    // Asynchronous reset in the middle of EXECUTE with pc = 0x0123
    run_one(1'b1, 16'h0123);
    check("pc_0123", {16'd0, pc}, 32'h0123);
    run = 1'b1;
    repeat (3) tick();
    check("in_exec", {31'd0, exec_stb}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_pc", {16'd0, pc}, 32'h0000);
    check("async_stb", {27'd0, dut_stb()}, 32'd0);
    check("async_halted", {31'd0, halted}, 32'd1);
    check("async_cnt", {16'd0, instr_count}, 32'd0);
    model_reset();
    run = 1'b0;
    tick();
    rst_n = 1'b1;

    // Ten back-to-back instructions from reset
    run = 1'b1; mem_ready = 1'b1; set_pc = 1'b0; halt_req = 1'b0;
    repeat (51) tick();
    check("ten_pc", {16'd0, pc}, 32'h000A);
    check("ten_cnt", {16'd0, instr_count}, 32'd10);
    check("ten_fetch", {31'd0, fetch_stb}, 32'd1);
    run = 1'b0;
    n = 0;
    while (!halted && n < 30) begin
      tick();
      n++;
    end
    check("ten_stop", {31'd0, halted}, 32'd1);

    // PC wrap and explicit jump
    run_one(1'b1, 16'hFFFF);
    check("pc_ffff", {16'd0, pc}, 32'hFFFF);
    run_one(1'b0, 16'h1234);
    check("pc_wrap", {16'd0, pc}, 32'h0000);
    run_one(1'b1, 16'h0040);
    check("pc_jump", {16'd0, pc}, 32'h0040);

    // Three step pulses spaced 10 cycles with run low
    base = instr_count;
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      repeat (9) tick();
    end
    check("step_count", {16'd0, instr_count}, {16'd0, base + 16'(3 * STEP_EN)});

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      run       = ($urandom_range(0, 9) > 2);
      halt_req  = ($urandom_range(0, 19) == 0);
      mem_ready = ($urandom_range(0, 9) < 7);
      set_pc    = $urandom_range(0, 1) != 0;
      jump_addr = 16'($urandom);
      step      = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_phase_sequencer.md
# cpu_phase_sequencer

Generates the five per-instruction phase strobes (fetch, decode, execute, write-back, jump) that drive the CPU core. Owns the program counter: increments it, or loads the jump target when the control unit's `set_pc` is asserted. Also provides run/halt control, a write-back wait for slow memory, and a retired-instruction counter. Sits between the top-level clock/debug logic and the control unit, ROM, ALU and register file.

## Interface
- `RESET_PC`, 16'h0000, value loaded into `pc` on reset.
- `clk`  in  1  single core clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `run`  in  1  level; high = execute continuously.
- `halt_req`  in  1  level; stop at the next instruction boundary.
- `step`  in  1  one-cycle pulse; execute one instruction (see Configuration).
- `mem_ready`  in  1  memory write complete; sampled only in WRBK.
- `set_pc`  in  1  from control unit; sampled only in JMP.
- `jump_addr`  in  16  jump target (A register); sampled only in JMP.
- `pc`  out  16  program counter; ROM address.
- `fetch_stb`, `decode_stb`, `exec_stb`, `wrbk_stb`, `jmp_stb`  out  1 each  registered phase strobes.
- `halted`  out  1  high while in IDLE.
- `instr_count`  out  16  retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRBK, JMP. One-hot or binary encoding is free, but no unreachable-state lockup: any illegal encoding → IDLE.
- IDLE: `run`=1 → FETCH; otherwise stay (single-step: see Configuration).
- FETCH → DECODE → EXECUTE → WRBK: unconditional, one cycle each.
- WRBK: `mem_ready`=1 → JMP; else stay. `mem_ready` is checked in every WRBK cycle, including the first.
- JMP updates state as follows:
  - `pc` ← `set_pc` ? `jump_addr` : `pc`+1. The increment is modulo 2^16, so 16'hFFFF → 16'h0000.
  - `instr_count` ← `instr_count`+1, wrapping FFFF → 0000.
  - Next state: `halt_req`=1 or `run`=0 or step-in-progress → IDLE; else FETCH.
- `halt_req` is honoured only in JMP. An instruction in flight always completes. `halt_req` and `run` both high in IDLE: `run` wins; the instruction runs and halts at its JMP.
- Strobes: exactly one strobe high per cycle, none in IDLE. Each phase's strobe is high in the first cycle the FSM spends in that phase. During a WRBK stall, `wrbk_stb` is high only on the first WRBK cycle.
- Reset (any time, including mid-instruction) forces:
  - state IDLE, `pc`=`RESET_PC`, `instr_count`=0, all strobes 0, `halted`=1.
  - Release needs no special sequencing; the first edge after `rst_n` rises is evaluated from IDLE.

## Timing
- All outputs are registered; no combinational input→output paths.
- `run` sampled high in IDLE at edge k gives:
  - `fetch_stb` in cycle k+1, `decode_stb` k+2, `exec_stb` k+3, `wrbk_stb` k+4.
  - `jmp_stb` k+5, provided `mem_ready`=1 at the edge ending k+4.
  - New `pc` and `instr_count` visible in cycle k+6, concurrent with the next `fetch_stb`.
- Throughput: 5 cycles per instruction with no stall; each stall cycle adds 1.
- `halted` rises in the cycle after JMP when stopping, and falls in the cycle the FSM leaves IDLE.
- `pc` is stable from JMP+1 through the following JMP cycle.

## Configuration
- `SEQ_SINGLE_STEP_EN` defined:
  - In IDLE with `run`=0, a `step` pulse starts one instruction: FETCH…JMP, then return to IDLE.
  - `step` outside IDLE is ignored.
  - If `step` and `run` are both high in IDLE, behaviour follows `run`.
- Not defined: `step` is ignored; the port remains for interface stability.

## Test plan
- Reset mid-EXECUTE with `pc`=0x0123: assert `rst_n`=0 → `pc`=RESET_PC, all strobes 0, `halted`=1, immediately (asynchronous, no clock edge needed).
- `run`=1, `mem_ready`=1, `set_pc`=0 from reset, 10 instructions → strobes cycle F,D,E,W,J each 5 cycles; `pc`=0x000A; `instr_count`=10.
- `mem_ready` held low 3 WRBK cycles → `wrbk_stb` is one pulse, JMP occurs 3 cycles late, and `pc` advances by exactly 1.
- `pc`=0xFFFF, `set_pc`=0 → `pc`=0x0000. Separately, `set_pc`=1 with `jump_addr`=0x0040 → `pc`=0x0040.
- `halt_req` raised during DECODE → instruction completes, IDLE after JMP, `halted`=1, `pc` updated once, no further `fetch_stb`.
- With `SEQ_SINGLE_STEP_EN`: `run`=0, three `step` pulses spaced 10 cycles → `instr_count`=3, with `halted` low only during each 5-cycle instruction. Without the macro, the same stimulus leaves `instr_count`=0.
